// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder for the pipelined MIPS core: word RAM plus an MMIO
// window holding a cycle counter, a compare timer and a TX mailbox FIFO.
module dmem_mmio_responder #(
  parameter int unsigned RAM_ADDR_W = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_CMP    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STAT   = 8'h0C;
  localparam logic [7:0] OFF_TXDATA = 8'h10;
  localparam logic [7:0] OFF_TXSTAT = 8'h14;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  mmio_sel;
  logic [7:0]            offset;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  ram_we;
  logic                  mmio_we;
  logic                  wr_cmp, wr_ctrl, wr_stat, wr_txstat;
  logic                  push_req;

  assign mmio_sel  = (memaddr[31:16] == MMIO_BASE);
  assign offset    = memaddr[7:0];
  assign ram_idx   = memaddr[RAM_ADDR_W+1:2];
  assign ram_we    = memwrite & ~mmio_sel;
  assign mmio_we   = memwrite & mmio_sel;
  assign wr_cmp    = mmio_we & (offset == OFF_CMP);
  assign wr_ctrl   = mmio_we & (offset == OFF_CTRL);
  assign wr_stat   = mmio_we & (offset == OFF_STAT);
  assign wr_txstat = mmio_we & (offset == OFF_TXSTAT);
  assign push_req  = mmio_we & (offset == OFF_TXDATA);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{memaddr[15:8], memaddr[1:0]};

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_DEPTH];
  logic [31:0] ram_rdata;

  // NOTE: storage arrays carry no reset; resetting them would force a flop
  // array instead of RAM and the contents are undefined by contract anyway.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= memwritedata;
  end

  // Reading the pre-edge array gives old data on a same-cycle read/write.
  assign ram_rdata = ram_q[ram_idx];

  // ---------------------------------------------------------------------------
  // Cycle counter and compare timer
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        flag_q, flag_d;

  assign cycle_d = cycle_q + 32'd1;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cmp_d  = cmp_q;
    en_d   = en_q;
    flag_d = flag_q;
    if (wr_cmp)                    cmp_d  = memwritedata;
    if (wr_ctrl)                   en_d   = memwritedata[0];
    if (wr_stat && memwritedata[0]) flag_d = 1'b0;
    // A match in the same cycle as a clear-write keeps the flag set.
    if (en_q && (cycle_q == cmp_q)) flag_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
    end
  end

  assign timer_irq = flag_q;

  // ---------------------------------------------------------------------------
  // TX mailbox FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, pop, push;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push  = push_req & (~full | pop);

  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push);
    rptr_d  = rptr_q + PTR_W'(pop);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_txstat && memwritedata[8]) ovf_d = 1'b0;
    if (push_req && full && !pop)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) fifo_q[wptr_q] <= memwritedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_valid = ~empty;
  assign tx_data  = tx_valid ? fifo_q[rptr_q] : '0;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      OFF_CYCLE:  mmio_rdata = cycle_q;
      OFF_CMP:    mmio_rdata = cmp_q;
      OFF_CTRL:   mmio_rdata = {31'b0, en_q};
      OFF_STAT:   mmio_rdata = {31'b0, flag_q};
      OFF_TXSTAT: mmio_rdata = {23'b0, ovf_q, 6'(count_q), empty, full};
      default:    mmio_rdata = '0;
    endcase
  end

  assign memreaddata = mmio_sel ? mmio_rdata : ram_rdata;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, cycle counter, timer, TX FIFO
// and reset behaviour, each scenario in its own task with hand-computed values.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT   = 32'hFFFF_000C;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        timer_irq;

  int checks   = 0;
  int failures = 0;
  int unsigned model_cyc = 0;

  dmem_mmio_responder dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  // Reference cycle count: 0 in the first cycle after reset releases.
  always @(posedge clk) begin
    if (reset) model_cyc <= 0;
    else       model_cyc <= model_cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr      = a;
    memwritedata = d;
    memwrite     = 1'b1;
    step();
    memwrite     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    #1;
    d = memreaddata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned k);
    int n = 0;
    while (model_cyc != k && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (model_cyc != k) begin
      failures++;
      $display("FAIL wait_cyc got=%0d exp=%0d", model_cyc, k);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%0h exp=0", tx_valid); end
    checks++; if (tx_data !== 32'h0) begin failures++; $display("FAIL rst_tx_data got=%h exp=0", tx_data); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%0h exp=0", timer_irq); end
    rd(A_CYCLE, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_cycle0 got=%h exp=0", d); end
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h002) begin failures++; $display("FAIL rst_txstat got=%h exp=002", d); end
    rd(A_CMP, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_cmp got=%h exp=0", d); end
    repeat (4) step();
    rd(A_CYCLE, d);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL cycle_5th got=%h exp=4", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h0000_0010, 32'hDEADBEEF);
    rd(32'h0000_0010, d);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rd got=%h exp=deadbeef", d); end
    rd(32'h0000_0013, d);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rd_byteoff got=%h exp=deadbeef", d); end
    rd(32'h0000_0110, d);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_alias got=%h exp=deadbeef", d); end
    // Same-cycle read of the location being written returns the old word.
    wr(32'h0000_0020, 32'h1111_1111);
    memaddr      = 32'h0000_0020;
    memwritedata = 32'h2222_2222;
    memwrite     = 1'b1;
    #1;
    checks++; if (memreaddata !== 32'h1111_1111) begin failures++; $display("FAIL ram_rw_old got=%h exp=11111111", memreaddata); end
    step();
    memwrite = 1'b0;
    rd(32'h0000_0020, d);
    checks++; if (d !== 32'h2222_2222) begin failures++; $display("FAIL ram_rw_new got=%h exp=22222222", d); end
    // MMIO write to an unmapped offset whose index aliases a RAM word.
    wr(32'h0000_0080, 32'h1234_5678);
    wr(32'hFFFF_0080, 32'h0000_CAFE);
    rd(32'h0000_0080, d);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL mmio_no_ram got=%h exp=12345678", d); end
    rd(32'hFFFF_0080, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", d); end
    // CYCLE is read-only.
    wr(A_CYCLE, 32'h0000_1234);
    rd(A_CYCLE, d);
    checks++; if (d !== model_cyc) begin failures++; $display("FAIL cycle_ro got=%h exp=%h", d, model_cyc); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    do_reset();
    wr(A_CMP, 32'd20);
    wr(A_CTRL, 32'hFFFF_FFFF);
    rd(A_CMP, d);
    checks++; if (d !== 32'd20) begin failures++; $display("FAIL tmr_cmp_rd got=%h exp=14", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL tmr_ctrl_rd got=%h exp=1", d); end
    wait_cyc(20);
    rd(A_CYCLE, d);
    checks++; if (d !== 32'd20) begin failures++; $display("FAIL tmr_cycle20 got=%h exp=14", d); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL tmr_pre got=%0h exp=0", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL tmr_set got=%0h exp=1", timer_irq); end
    rd(A_STAT, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL tmr_stat got=%h exp=1", d); end
    wait_cyc(25);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL tmr_sticky got=%0h exp=1", timer_irq); end
    wr(A_STAT, 32'h1);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL tmr_clear got=%0h exp=0", timer_irq); end
    wr(A_CMP, 32'd40);
    wait_cyc(40);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL tmr_pre40 got=%0h exp=0", timer_irq); end
    wr(A_STAT, 32'h1);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL tmr_set_wins got=%0h exp=1", timer_irq); end
    wr(A_CTRL, 32'h0);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL tmr_disable_keeps got=%0h exp=1", timer_irq); end
    wr(A_STAT, 32'h1);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL tmr_clear2 got=%0h exp=0", timer_irq); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_TXDATA, 32'(i));
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h011) begin failures++; $display("FAIL fifo_full_stat got=%h exp=011", d); end
    wr(A_TXDATA, 32'd5);
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h111) begin failures++; $display("FAIL fifo_ovf_stat got=%h exp=111", d); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 32'd1) begin failures++; $display("FAIL fifo_stable got=%0h/%h exp=1/1", tx_valid, tx_data); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin
        failures++;
        $display("FAIL fifo_drain%0d got=%0h/%h exp=1/%h", i, tx_valid, tx_data, i);
      end
      step();
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin failures++; $display("FAIL fifo_empty got=%0h/%h exp=0/0", tx_valid, tx_data); end
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h102) begin failures++; $display("FAIL fifo_empty_stat got=%h exp=102", d); end
    wr(A_TXSTAT, 32'h100);
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h002) begin failures++; $display("FAIL fifo_ovf_clr got=%h exp=002", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'd6; exp_seq[1] = 32'd7; exp_seq[2] = 32'd8; exp_seq[3] = 32'd9;
    tx_ready = 1'b0;
    for (int i = 5; i <= 8; i++) wr(A_TXDATA, 32'(i));
    // Push and pop in the same cycle while full.
    memaddr      = A_TXDATA;
    memwritedata = 32'd9;
    memwrite     = 1'b1;
    tx_ready     = 1'b1;
    #1;
    checks++; if (tx_data !== 32'd5) begin failures++; $display("FAIL b2b_head got=%h exp=5", tx_data); end
    step();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h011) begin failures++; $display("FAIL b2b_stat got=%h exp=011", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
        failures++;
        $display("FAIL b2b_drain%0d got=%0h/%h exp=1/%h", i, tx_valid, tx_data, exp_seq[i]);
      end
      step();
    end
    tx_ready = 1'b0;
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h002) begin failures++; $display("FAIL b2b_end_stat got=%h exp=002", d); end
    // Push and pop with a single entry: head advances to the new word.
    wr(A_TXDATA, 32'hA);
    memaddr      = A_TXDATA;
    memwritedata = 32'hB;
    memwrite     = 1'b1;
    tx_ready     = 1'b1;
    step();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 32'hB) begin failures++; $display("FAIL cnt1_head got=%0h/%h exp=1/b", tx_valid, tx_data); end
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h004) begin failures++; $display("FAIL cnt1_stat got=%h exp=004", d); end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL cnt1_drain got=%0h exp=0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] c;
    tx_ready = 1'b0;
    c = model_cyc;
    wr(A_CMP, c + 32'd5);
    wr(A_CTRL, 32'h1);
    for (int i = 1; i <= 3; i++) wr(A_TXDATA, 32'h100 + 32'(i));
    step();
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL mid_irq_pre got=%0h exp=1", timer_irq); end
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h00C) begin failures++; $display("FAIL mid_stat_pre got=%h exp=00c", d); end
    reset        = 1'b1;
    memaddr      = A_TXDATA;
    memwritedata = 32'h77;
    memwrite     = 1'b1;
    step();
    reset    = 1'b0;
    memwrite = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 32'h0) begin failures++; $display("FAIL mid_tx got=%0h/%h exp=0/0", tx_valid, tx_data); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%0h exp=0", timer_irq); end
    rd(A_TXSTAT, d);
    checks++; if (d !== 32'h002) begin failures++; $display("FAIL mid_stat got=%h exp=002", d); end
    rd(A_CYCLE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_cycle got=%h exp=0", d); end
    step();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_push_dropped got=%0h exp=0", tx_valid); end
  endtask

  initial begin
    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = '0;
    memwritedata = '0;
    tx_ready     = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
